gray_ptr_sync: RTL and testbench

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

---
 rtl/gray_ptr_sync.sv | 118 +++++++++++
 tb/tb_gray_ptr_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer synchroniser: multi-flop sync chain, Gray-to-binary conversion,
// step delta, fill-based valid flag and a sticky flag for illegal multi-bit Gray steps.
module gray_ptr_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PIPE        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] delta,
    output logic             bin_valid,
    output logic             step_err
);

    localparam int          LAT   = SYNC_STAGES + 1 + PIPE;
    localparam logic [2:0]  LAT_C = 3'(LAT);

    if (WIDTH < 2 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        (PIPE != 0 && PIPE != 1)) begin : g_bad_param
        $error("gray_ptr_sync: parameter out of legal range");
    end

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic [2:0]       fill_q, fill_d;
    logic             bin_valid_q, bin_valid_d;
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] bin_conv;
    logic [WIDTH-1:0] bin_src;
    logic [WIDTH-1:0] gray_diff;
    logic             multi_step;

    assign gray_sync = sync_q[SYNC_STAGES-1];
    assign bin_conv  = gray2bin(gray_sync);

    // Optional register between the converter and bin_out to relax timing.
    if (PIPE != 0) begin : g_pipe
        logic [WIDTH-1:0] pipe_q, pipe_d;
        always_comb pipe_d = bin_conv;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe_q <= '0;
            else        pipe_q <= pipe_d;
        end
        assign bin_src = pipe_q;
    end else begin : g_no_pipe
        assign bin_src = bin_conv;
    end

    // A difference with more than one set bit means a Hamming distance above 1.
    assign gray_diff  = gray_sync ^ gray_prev_q;
    assign multi_step = |(gray_diff & (gray_diff - WIDTH'(1)));

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so no latch is inferred; state updates below use non-blocking '<='.
    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        gray_prev_d = gray_sync;
        bin_out_d   = bin_src;
        delta_d     = bin_valid_q ? (bin_src - bin_out_q) : '0;
        fill_d      = (fill_q == LAT_C) ? fill_q : fill_q + 3'd1;
        bin_valid_d = bin_valid_q | (fill_q == LAT_C - 3'd1);
        step_err_d  = step_err_q;
        if (bin_valid_q && multi_step) begin
            step_err_d = 1'b1;
        end else if (err_clr) begin
            step_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            gray_prev_q <= '0;
            bin_out_q   <= '0;
            delta_q     <= '0;
            fill_q      <= '0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            gray_prev_q <= gray_prev_d;
            bin_out_q   <= bin_out_d;
            delta_q     <= delta_d;
            fill_q      <= fill_d;
            bin_valid_q <= bin_valid_d;
            step_err_q  <= step_err_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign delta     = delta_q;
    assign bin_valid = bin_valid_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync (WIDTH=4, SYNC_STAGES=2, PIPE=0): per-cycle comparison
// against a history-based model, plus directed literal expectations.
module tb_gray_ptr_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] gray_sync, bin_out, delta;
    logic       bin_valid, step_err;

    int n_checks = 0;
    int n_pass   = 0;

    gray_ptr_sync #(.WIDTH(4), .SYNC_STAGES(2), .PIPE(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .gray_sync (gray_sync),
        .bin_out   (bin_out),
        .delta     (delta),
        .bin_valid (bin_valid),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: gray_in values captured at each edge since reset release.
    logic [3:0] g_hist [0:1023];
    int         n_edge = 0;
    logic [3:0] m_bo_prev = '0;
    logic       m_err = 1'b0;

    function automatic logic [3:0] to_bin(input logic [3:0] g);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [3:0] gs_at(input int k);
        return (k >= 2) ? g_hist[k-1] : 4'd0;
    endfunction

    always @(posedge clk) begin
        logic [3:0] e_gs, e_bo, e_dl;
        logic       e_v;
        if (!rst_n) begin
            n_edge    = 0;
            m_bo_prev = '0;
            m_err     = 1'b0;
            #1;
            check("rst_all_zero", {gray_sync, bin_out, delta, bin_valid, step_err}, '0);
        end else begin
            n_edge++;
            if (n_edge < 1024) g_hist[n_edge] = gray_in;
            e_gs = gs_at(n_edge);
            e_bo = (n_edge >= 3) ? to_bin(gs_at(n_edge - 1)) : 4'd0;
            e_v  = (n_edge >= 3);
            e_dl = (n_edge >= 4) ? 4'(e_bo - m_bo_prev) : 4'd0;
            if (n_edge >= 4 && $countones(gs_at(n_edge - 1) ^ gs_at(n_edge - 2)) > 1)
                m_err = 1'b1;
            else if (err_clr)
                m_err = 1'b0;
            m_bo_prev = e_bo;
            #1;
            check("m_gray_sync", gray_sync, e_gs);
            check("m_bin_out",   bin_out,   e_bo);
            check("m_delta",     delta,     e_dl);
            check("m_bin_valid", bin_valid, e_v);
            check("m_step_err",  step_err,  m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        gray_in = 4'b1010;
        err_clr = 1'b0;
        tick(2);
        check("reset_outputs", {gray_sync, bin_out, delta, bin_valid, step_err}, '0);

        // Fill after release: valid on 3rd edge with bin_out = bin(1010) = 1100.
        rst_n = 1'b1;
        tick(2);
        check("fill_valid_e2", bin_valid, 1'b0);
        tick(1);
        check("fill_valid_e3", bin_valid, 1'b1);
        check("fill_bin_e3",   bin_out,   4'b1100);
        check("fill_delta_e3", delta,     4'd0);

        // 1010 -> 0000 is a two-bit jump; then a lone err_clr clears it.
        gray_in = 4'b0000;
        tick(4);
        check("jump_err_set", step_err, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("lone_clear", step_err, 1'b0);

        // Count 0,1,2,3.
        gray_in = 4'b0001; tick(1);
        gray_in = 4'b0011; tick(1);
        gray_in = 4'b0010; tick(3);
        check("count_bin3",   bin_out,  4'd3);
        check("count_delta",  delta,    4'd1);
        check("count_no_err", step_err, 1'b0);

        // Walk up to 15 then wrap to 0.
        for (int i = 4; i <= 15; i++) begin
            gray_in = 4'(i ^ (i >> 1));
            tick(1);
        end
        tick(2);
        check("wrap_bin15", bin_out, 4'd15);
        gray_in = 4'b0000;
        tick(3);
        check("wrap_bin0",   bin_out,  4'd0);
        check("wrap_delta",  delta,    4'd1);
        check("wrap_no_err", step_err, 1'b0);

        // Illegal 0000 -> 0011, then legal steps keep converting with error held.
        gray_in = 4'b0011;
        tick(3);
        check("ill_bin",   bin_out,  4'd2);
        check("ill_delta", delta,    4'd2);
        check("ill_err",   step_err, 1'b1);
        gray_in = 4'b0010; tick(1);
        gray_in = 4'b0110; tick(3);
        check("ill_follow_bin",   bin_out,  4'd4);
        check("ill_follow_delta", delta,    4'd1);
        check("ill_err_held",     step_err, 1'b1);

        // Coincident clear and 0011 -> 0000 jump: set wins.
        gray_in = 4'b0010; tick(1);
        gray_in = 4'b0011; tick(1);
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0; tick(2);
        check("pre_coinc_clear", step_err, 1'b0);
        gray_in = 4'b0000;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("coinc_set_wins", step_err, 1'b1);

        // Mid-run asynchronous reset while bin_out = 5.
        for (int i = 1; i <= 5; i++) begin
            gray_in = 4'(i ^ (i >> 1));
            tick(1);
        end
        tick(2);
        check("pre_rst_bin5", bin_out, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_zero", {gray_sync, bin_out, delta, bin_valid, step_err}, '0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("refill_e1", bin_valid, 1'b0);
        tick(1);
        check("refill_e2", bin_valid, 1'b0);
        tick(1);
        check("refill_e3_valid", bin_valid, 1'b1);
        check("refill_e3_bin",   bin_out,   4'd5);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
